// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI host control path: HOST_DATA bit map,
// control state encoding and the CONTROL readback layout.
package spi_ctrl_pkg;

  localparam int unsigned BIT_START    = 0;
  localparam int unsigned BIT_SOFT_CLR = 1;
  localparam int unsigned BIT_CPOL     = 2;
  localparam int unsigned BIT_CPHA     = 3;
  localparam int unsigned BIT_DIV_LO   = 4;
  localparam int unsigned BIT_DIV_HI   = 5;
  localparam int unsigned BIT_FAIL_CLR = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } ctrl_state_t;

  // Readback byte: {2'b00, CLK_DIV, CPHA, CPOL, 1'b0, BUSY}
  function automatic logic [7:0] control_byte(input logic [1:0] clk_div,
                                              input logic       cpha,
                                              input logic       cpol,
                                              input logic       busy);
    return {2'b00, clk_div, cpha, cpol, 1'b0, busy};
  endfunction

endpackage

// File: rtl/spi_ack_timeout.sv
// Acknowledge-timeout counter: loadable, clearable, counts when enabled and
// flags when it has reached TIMEOUT_CYCLES-1.
module spi_ack_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/spi_control_register.sv
// Host control register for the SPI block: mode fields, SOFT_CLR pulse,
// transfer request/acknowledge handshake and sticky acknowledge-timeout flag.
module spi_control_register
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       S_CLK,
  input  logic       CLR_N,
  input  logic       HOST_WRITE,
  input  logic [7:0] HOST_DATA,
  input  logic       TRANSFER_ACK,
  input  logic       TRANSFER_DONE,
  output logic [7:0] CONTROL,
  output logic       CPOL,
  output logic       CPHA,
  output logic [1:0] CLK_DIV,
  output logic       SOFT_CLR,
  output logic       TRANSFER_REQ,
  output logic       BUSY,
  output logic       CONNECTION_FAILED_STATE
);

  ctrl_state_t state;

  logic soft_clr_wr;
  logic fail_clr_wr;
  logic start_ok;
  logic timeout;
  logic expired;
  logic cnt_clear;
  logic cnt_enable;
  logic unused_reserved;

  assign unused_reserved = HOST_DATA[7];

  always_comb begin
    soft_clr_wr = HOST_WRITE && HOST_DATA[BIT_SOFT_CLR];
    fail_clr_wr = HOST_WRITE && HOST_DATA[BIT_FAIL_CLR];
    // A pending failure blocks START unless the same write also clears it.
    start_ok    = (state == ST_IDLE) && HOST_WRITE && HOST_DATA[BIT_START] &&
                  !HOST_DATA[BIT_SOFT_CLR] &&
                  (!CONNECTION_FAILED_STATE || HOST_DATA[BIT_FAIL_CLR]);
    timeout     = (state == ST_REQ) && !TRANSFER_ACK && !soft_clr_wr && expired;
    cnt_clear   = soft_clr_wr || ((state == ST_REQ) && (TRANSFER_ACK || expired));
    cnt_enable  = (state == ST_REQ) && !TRANSFER_ACK && !expired;
  end

  spi_ack_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ack_timeout (
    .clk        (S_CLK),
    .rst_n      (CLR_N),
    .clear      (cnt_clear),
    .load       (start_ok),
    .load_value ('0),
    .enable     (cnt_enable),
    .expired    (expired)
  );

  always_ff @(posedge S_CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state                   <= ST_IDLE;
      CPOL                    <= 1'b0;
      CPHA                    <= 1'b0;
      CLK_DIV                 <= '0;
      SOFT_CLR                <= 1'b0;
      TRANSFER_REQ            <= 1'b0;
      BUSY                    <= 1'b0;
      CONNECTION_FAILED_STATE <= 1'b0;
    end else begin
      SOFT_CLR <= soft_clr_wr;

      // Timeout wins over a FAIL_CLR arriving on the same edge.
      if (timeout) begin
        CONNECTION_FAILED_STATE <= 1'b1;
      end else if (fail_clr_wr) begin
        CONNECTION_FAILED_STATE <= 1'b0;
      end

      if ((state == ST_IDLE) && HOST_WRITE) begin
        CPOL    <= HOST_DATA[BIT_CPOL];
        CPHA    <= HOST_DATA[BIT_CPHA];
        CLK_DIV <= HOST_DATA[BIT_DIV_HI:BIT_DIV_LO];
      end

      if (soft_clr_wr) begin
        state        <= ST_IDLE;
        TRANSFER_REQ <= 1'b0;
        BUSY         <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_ok) begin
              state        <= ST_REQ;
              TRANSFER_REQ <= 1'b1;
              BUSY         <= 1'b1;
            end
          end
          ST_REQ: begin
            if (TRANSFER_ACK) begin
              state        <= ST_ACTIVE;
              TRANSFER_REQ <= 1'b0;
            end else if (expired) begin
              state        <= ST_IDLE;
              TRANSFER_REQ <= 1'b0;
              BUSY         <= 1'b0;
            end
          end
          ST_ACTIVE: begin
            if (TRANSFER_DONE) begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
          end
          default: begin
            state        <= ST_IDLE;
            TRANSFER_REQ <= 1'b0;
            BUSY         <= 1'b0;
          end
        endcase
      end
    end
  end

  assign CONTROL = control_byte(CLK_DIV, CPHA, CPOL, BUSY);

endmodule

// File: doc/spi_control_register.md
# spi_control_register

Host-side control register for the SPI interface, the write-path counterpart of the status byte the host reads back. It latches the host's 8-bit control writes into mode outputs (CPOL, CPHA, clock divider). It turns write-1 command bits into single-cycle clear pulses and a request/acknowledge handshake with the transfer engine. It also runs the acknowledge-timeout counter that raises CONNECTION_FAILED_STATE.

## Interface

Parameters:
- TIMEOUT_CYCLES, 255: cycles TRANSFER_REQ may stay high without TRANSFER_ACK before failure; legal range 1..2^CNT_W.
- CNT_W, 8: timeout counter width.

Ports:
- S_CLK, in, 1: the only clock; all logic is on the rising edge.
- CLR_N, in, 1: reset, asynchronous, active-low.
- HOST_WRITE, in, 1: write strobe, sampled on the S_CLK edge.
- HOST_DATA, in, 8: control byte, valid while HOST_WRITE is high.
- TRANSFER_ACK, in, 1: transfer engine accepted the request.
- TRANSFER_DONE, in, 1: transfer engine finished (1-cycle pulse).
- CONTROL, out, 8: readback byte {2'b00, CLK_DIV, CPHA, CPOL, 1'b0, BUSY}.
- CPOL, out, 1: clock polarity.
- CPHA, out, 1: clock phase.
- CLK_DIV, out, 2: SCK divider select.
- SOFT_CLR, out, 1: one-cycle clear pulse to the FIFOs and status logic.
- TRANSFER_REQ, out, 1: start request to the transfer engine.
- BUSY, out, 1: high when state ≠ IDLE.
- CONNECTION_FAILED_STATE, out, 1: sticky timeout flag.

## Operation

HOST_DATA bit map:
- [0] START: write-1 only, self-clearing.
- [1] SOFT_CLR: write-1 only, self-clearing.
- [2] CPOL.
- [3] CPHA.
- [5:4] CLK_DIV.
- [6] FAIL_CLR: write-1 only.
- [7] reserved; ignored.

State machine (IDLE, REQ, ACTIVE):
- IDLE → REQ: on a write with START=1 and SOFT_CLR=0, when CONNECTION_FAILED_STATE is 0 or FAIL_CLR=1 in the same write. The timeout counter loads 0.
- REQ → ACTIVE: TRANSFER_ACK=1.
- REQ → IDLE (timeout): no ack and counter = TIMEOUT_CYCLES−1. CONNECTION_FAILED_STATE is set.
- REQ, no ack, below limit: the counter increments.
- ACTIVE → IDLE: TRANSFER_DONE=1.
- Any state → IDLE: a write with SOFT_CLR=1 aborts. TRANSFER_REQ drops and the counter clears.

Field rules:
- CPOL, CPHA and CLK_DIV update only on writes accepted in IDLE. While BUSY, these fields and START are ignored.
- SOFT_CLR and FAIL_CLR are honored in every state.
- Outputs in reset and after CLR_N deasserts:
  - all outputs 0, CONTROL = 8'h00;
  - state IDLE, counter 0.

## Timing

- All outputs are registered; CONTROL is a function of registers only.
- SOFT_CLR: high for exactly the one cycle after the write edge. Back-to-back writes give back-to-back pulses.
- TRANSFER_REQ: rises the cycle after an accepted START write. It stays high until the cycle after TRANSFER_ACK is sampled.
- Timeout: with no ack, TRANSFER_REQ is high for exactly TIMEOUT_CYCLES cycles. On the following cycle REQ is 0, CONNECTION_FAILED_STATE is 1 and BUSY is 0.
- Simultaneous events:
  - ACK in the last REQ cycle beats timeout: no failure.
  - START and SOFT_CLR in the same write: SOFT_CLR wins and START is dropped.
  - Timeout and FAIL_CLR in the same cycle: the flag ends set.
  - SOFT_CLR and TRANSFER_DONE in ACTIVE in the same cycle: IDLE, pulse issued.
- TRANSFER_DONE outside ACTIVE is ignored. TRANSFER_ACK outside REQ is ignored.
- CLR_N asserted mid-transfer: REQ, BUSY and flags drop asynchronously. No SOFT_CLR pulse is generated.

## Structure

- Shared package spi_ctrl_pkg holds:
  - the bit indices for START, SOFT_CLR, CPOL, CPHA, CLK_DIV and FAIL_CLR;
  - the state encoding for IDLE, REQ and ACTIVE;
  - the CONTROL readback layout.
- spi_status (the status combiner) uses the same package.
- One sub-module, spi_ack_timeout: loadable CNT_W counter with clear, enable and an expired output. Everything else stays flat.

## Test plan

- Reset, then write 8'h34 in IDLE → CPOL=1, CPHA=0, CLK_DIV=2'b11, CONTROL=8'h34, no REQ.
- Write 8'h01; ACK on cycle 3 of REQ; DONE 5 cycles later:
  - REQ high cycles 1–3, drops cycle 4;
  - BUSY high from cycle 1 through the DONE cycle;
  - CONTROL[0] follows BUSY.
- TIMEOUT_CYCLES=4, write 8'h01, never ACK:
  - REQ high exactly 4 cycles, then FAILED=1;
  - a second write of 8'h01 is ignored;
  - a write of 8'h41 clears FAILED and starts REQ.
- Write 8'h0C while ACTIVE → CPOL and CPHA unchanged. Write 8'h02 while ACTIVE → SOFT_CLR one cycle, REQ low, BUSY low next cycle.
- Write 8'h03 in IDLE → SOFT_CLR pulse, no REQ. Assert CLR_N=0 mid-REQ → all outputs 0 immediately, without waiting for a clock edge.
